ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch and program-counter unit for the non-pipelined MIPS core. Owns the PC, fetches one 32-bit instruction per step from instruction memory over a req/ack handshake, and presents the instruction word and its opcode to the main control decoder. It consumes the decoder's `jump` and `branch` outputs and the ALU `zero` flag to compute the next PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- `clk`  in  1  core clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch byte address; equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  registered instruction word.
- `opcode`  out  6  `instr[31:26]`, drives the control decoder.
- `instr_valid`  out  1  `instr` is valid and executing.
- `exec_done`  in  1  datapath finished the current instruction; PC may advance.
- `jump`  in  1  from the control decoder.
- `branch`  in  1  from the control decoder.
- `zero`  in  1  ALU zero flag.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- IDLE: reset state. Unconditionally goes to FETCH on the next edge.
- FETCH: `imem_req`=1 and `imem_addr`=`pc` held stable until ack. When `imem_ack`=1, `instr` <= `imem_rdata` and the FSM goes to EXEC.
- EXEC: `instr_valid`=1, and `instr` and `pc` are frozen. When `exec_done`=1, `pc` <= next_pc and the FSM goes to FETCH. `jump`, `branch` and `zero` are sampled only in this cycle.
- next_pc priority:
  - `jump`=1: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `branch`&`zero`: `pc_plus4` + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else `pc_plus4`.
- Arithmetic is 32-bit and wraps modulo 2^32, with no overflow flag. Targets are always word aligned by construction.
- `jump` and `branch` asserted together: `jump` wins.
- `exec_done` outside EXEC and `imem_ack` outside FETCH are ignored.
- Reset (async, any state, including mid-fetch): FSM returns to IDLE immediately. Any pending ack is dropped and no memory abort is signalled. Memory must tolerate a withdrawn request.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
  - `instr`=0, `opcode`=0.
  - `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.
- `imem_req` and `instr_valid` are decoded from registered state (glitch-free). `opcode`, `imem_addr` and `pc_plus4` are combinational from registers.
- First request: the first rising edge after `rst_n` deasserts moves IDLE to FETCH, so `imem_req`=1 in cycle 1.
- Ack may arrive in the same cycle `imem_req` rises (zero-wait memory). Then `instr_valid`=1 in the following cycle.
- Minimum cost is 2 cycles per instruction: zero-wait memory plus `exec_done` asserted in the first EXEC cycle. Each memory wait state or `exec_done` delay cycle adds one cycle.
- The new `pc` is visible, with `imem_req`=1, in the cycle after the `exec_done` edge.

## Structure
- Shared package `mips_pkg`, common with the control decoder:
  - Opcode constants: `OP_RTYPE`=6'b000000, `OP_J`=6'b000010, `OP_BEQ`=6'b000100, `OP_LW`=6'b100011, `OP_SW`=6'b101011.
  - Fetch FSM state encoding.
  - `RESET_PC` default.
- One combinational sub-module, `next_pc_calc`:
  - Inputs: `pc_plus4`, `instr[25:0]`, `jump`, `branch`, `zero`.
  - Output: `next_pc`.
  - Reused by the future pipelined fetch stage.

## Test plan
- Reset/first fetch: hold `rst_n`=0 for 3 cycles, then release, with `RESET_PC`=0. Required: all reset values above while low; `imem_req`=1 and `imem_addr`=0 in the 1st cycle after release.
- Sequential with wait states: ack after 2 wait cycles, `imem_rdata`=32'h0000_0820 (R-type), `exec_done` 1 cycle later. Required: `opcode`=0 while `instr_valid`=1; next fetch at `imem_addr`=4.
- Jump: `pc`=32'h0040_0010, instr=32'h0810_0000, `jump`=1. Required: next `imem_addr`=32'h0040_0000.
- Branch taken and not taken: `pc`=32'h0000_0100, instr=32'h1000_FFFE (beq, offset −2).
  - `branch`=1, `zero`=1: next PC=32'h0000_00FC.
  - `zero`=0: next PC=32'h0000_0104.
- Wrap and priority: `pc`=32'hFFFF_FFFC with no branch or jump gives next PC=32'h0000_0000. `jump`=1 and `branch`=1 with `zero`=1 together gives the jump target.
- Reset mid-operation: assert `rst_n`=0 during FETCH with the ack arriving in the same cycle. Required: `instr` stays 0, `pc`=`RESET_PC`, and fetch restarts at `RESET_PC` after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Definitions shared between the MIPS fetch unit and the main control decoder:
// opcode constants, fetch FSM state encoding and the default reset vector.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Bit 0 marks FETCH and bit 1 marks EXEC, so the request/valid outputs are plain flop bits.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken-branch target or sequential PC.
// All arithmetic wraps modulo 2^32.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off_s;

  assign branch_off_s = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Select next PC, jump taking priority over branch
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off_s;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch and PC unit for the non-pipelined MIPS core: fetches one word per
// instruction over a req/ack handshake and advances the PC once the datapath is done.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic [31:0]  pc_plus4_s;
  logic [31:0]  next_pc_s;
  logic         load_instr_s;
  logic         load_pc_s;

  assign pc_plus4_s = pc_r + 32'd4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4 (pc_plus4_s),
    .instr    (instr_r[25:0]),
    .jump     (jump),
    .branch   (branch),
    .zero     (zero),
    .next_pc  (next_pc_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and load-enable decode; ack and exec_done only matter in their own state
  always_comb begin
    state_nxt_s  = state_r;
    load_instr_s = 1'b0;
    load_pc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          load_instr_s = 1'b1;
          state_nxt_s  = ST_EXEC;
        end else begin
          state_nxt_s  = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          load_pc_s   = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // PC and instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      instr_r <= 32'h0000_0000;
    end else begin
      if (load_pc_s) begin
        pc_r <= next_pc_s;
      end
      if (load_instr_s) begin
        instr_r <= imem_rdata;
      end
    end
  end

  assign imem_req    = state_r[0];
  assign instr_valid = state_r[1];
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign instr       = instr_r;
  assign opcode      = instr_r[31:26];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a behavioural model is checked on every falling edge,
// and hand-computed fetch addresses pin down the model at each instruction boundary.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        exec_done = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int n_vec = 0;
  int n_err = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .exec_done(exec_done), .jump(jump), .branch(branch),
    .zero(zero), .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;

  int          m_phase = PH_IDLE;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;

  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] iw,
                                             input logic j, input logic b, input logic z);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (j) return {seq[31:28], iw[25:0], 2'b00};
    if (b && z) return seq + ({{16{iw[15]}}, iw[15:0]} * 32'd4);
    return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_IDLE;
      m_pc    <= 32'h0;
      m_instr <= 32'h0;
    end else if (m_phase == PH_IDLE) begin
      m_phase <= PH_FETCH;
    end else if (m_phase == PH_FETCH && imem_ack) begin
      m_instr <= imem_rdata;
      m_phase <= PH_EXEC;
    end else if (m_phase == PH_EXEC && exec_done) begin
      m_pc    <= model_next(m_pc, m_instr, jump, branch, zero);
      m_phase <= PH_FETCH;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_imem_req", {31'd0, imem_req}, (m_phase == PH_FETCH) ? 32'd1 : 32'd0);
    chk("m_instr_valid", {31'd0, instr_valid}, (m_phase == PH_EXEC) ? 32'd1 : 32'd0);
    chk("m_pc", pc, m_pc);
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("m_instr", instr, m_instr);
    chk("m_opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
  end

  // Runs one instruction starting in FETCH; optional noise drives ignored inputs.
  task automatic do_instr(input logic [31:0] rdata, input int waits, input int delay,
                          input logic j, input logic b, input logic z,
                          input logic [31:0] exp_next, input logic [5:0] exp_op,
                          input logic noise);
    for (int i = 0; i < waits; i++) begin
      exec_done = noise;
      imem_ack  = 1'b0;
      @(posedge clk); #1;
    end
    exec_done  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_opcode", {26'd0, opcode}, {26'd0, exp_op});
    jump   = j;
    branch = b;
    zero   = z;
    for (int i = 0; i < delay; i++) begin
      if (noise) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else begin
        imem_ack   = 1'b0;
      end
      @(posedge clk); #1;
    end
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
    chk("next_addr", imem_addr, exp_next);
    chk("next_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_pc_plus4", pc_plus4, 32'h0000_0004);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0000);

    do_instr(32'h0000_0820, 2, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 6'b000000, 1'b1);
    do_instr(32'h0810_0004, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0040_0010, 6'b000010, 1'b0);
    do_instr(32'h0810_0000, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0040_0000, 6'b000010, 1'b0);
    do_instr(32'h0800_0040, 0, 2, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 6'b000010, 1'b0);
    do_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_00FC, 6'b000100, 1'b0);
    do_instr(32'h0000_0820, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 6'b000000, 1'b0);
    do_instr(32'h1000_FFFE, 1, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 6'b000100, 1'b0);
    do_instr(32'h0800_0000, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 6'b000010, 1'b0);
    do_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 6'b000100, 1'b0);
    chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    do_instr(32'h0000_0820, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'b000000, 1'b0);
    do_instr(32'h0800_0040, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 6'b000010, 1'b0);

    // Reset during FETCH with the ack arriving in the same cycle
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0000_0000);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_instr", instr, 32'h0000_0000);
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0000_0000);
    do_instr(32'h0000_0820, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 6'b000000, 1'b0);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
